// File: rtl/l1_mem_arbiter_if.sv
`default_nettype none
// ==========================================================================
// l1_mem_arbiter_if: L1-side request/response bundle and L2-side port.
// Rev 1.0
// ==========================================================================
interface l1_mem_arbiter_if #(
  parameter int NUM_REQS     = 5,
  parameter int ADDR_WIDTH   = 26,
  parameter int DATA_WIDTH   = 512,
  parameter int TAG_IN_WIDTH = 8
);
  localparam int SEL_BITS      = $clog2(NUM_REQS);
  localparam int TAG_OUT_WIDTH = TAG_IN_WIDTH + SEL_BITS;
  localparam int BE_WIDTH      = DATA_WIDTH / 8;

  logic [NUM_REQS-1:0]                   req_in_valid;
  logic [NUM_REQS-1:0]                   req_in_rw;
  logic [NUM_REQS-1:0][BE_WIDTH-1:0]     req_in_byteen;
  logic [NUM_REQS-1:0][ADDR_WIDTH-1:0]   req_in_addr;
  logic [NUM_REQS-1:0][DATA_WIDTH-1:0]   req_in_data;
  logic [NUM_REQS-1:0][TAG_IN_WIDTH-1:0] req_in_tag;
  logic [NUM_REQS-1:0]                   req_in_ready;

  logic                     req_out_valid;
  logic                     req_out_rw;
  logic [BE_WIDTH-1:0]      req_out_byteen;
  logic [ADDR_WIDTH-1:0]    req_out_addr;
  logic [DATA_WIDTH-1:0]    req_out_data;
  logic [TAG_OUT_WIDTH-1:0] req_out_tag;
  logic                     req_out_ready;

  logic                     rsp_in_valid;
  logic [DATA_WIDTH-1:0]    rsp_in_data;
  logic [TAG_OUT_WIDTH-1:0] rsp_in_tag;
  logic                     rsp_in_ready;

  logic [NUM_REQS-1:0]      rsp_out_valid;
  logic [DATA_WIDTH-1:0]    rsp_out_data;
  logic [TAG_IN_WIDTH-1:0]  rsp_out_tag;
  logic [NUM_REQS-1:0]      rsp_out_ready;

  // Arbiter side.
  modport slave (
    input  req_in_valid, req_in_rw, req_in_byteen, req_in_addr, req_in_data, req_in_tag,
    output req_in_ready,
    output req_out_valid, req_out_rw, req_out_byteen, req_out_addr, req_out_data, req_out_tag,
    input  req_out_ready,
    input  rsp_in_valid, rsp_in_data, rsp_in_tag,
    output rsp_in_ready,
    output rsp_out_valid, rsp_out_data, rsp_out_tag,
    input  rsp_out_ready
  );

  // L1 clusters plus L2 side, as seen by whoever drives the arbiter.
  modport master (
    output req_in_valid, req_in_rw, req_in_byteen, req_in_addr, req_in_data, req_in_tag,
    input  req_in_ready,
    input  req_out_valid, req_out_rw, req_out_byteen, req_out_addr, req_out_data, req_out_tag,
    output req_out_ready,
    output rsp_in_valid, rsp_in_data, rsp_in_tag,
    input  rsp_in_ready,
    input  rsp_out_valid, rsp_out_data, rsp_out_tag,
    output rsp_out_ready
  );
endinterface
`default_nettype wire

// File: rtl/l1_mem_arbiter.sv
`default_nettype none
// ==========================================================================
// l1_mem_arbiter: round-robin L1->L2 request arbiter, tag-routed responses.
// Rev 1.0 -- sticky bursts enabled by defining L1_MEM_ARB_STICKY_EN.
// ==========================================================================
module l1_mem_arbiter #(
  parameter int NUM_REQS     = 5,
  parameter int ADDR_WIDTH   = 26,
  parameter int DATA_WIDTH   = 512,
  parameter int TAG_IN_WIDTH = 8,
  parameter int MAX_BURST    = 4
) (
  input  logic            clk,
  input  logic            reset,
  l1_mem_arbiter_if.slave bus
);
  localparam int SEL_BITS      = $clog2(NUM_REQS);
  localparam int TAG_OUT_WIDTH = TAG_IN_WIDTH + SEL_BITS;
  localparam int BE_WIDTH      = DATA_WIDTH / 8;
  localparam logic [SEL_BITS-1:0] LAST_RST = SEL_BITS'(NUM_REQS - 1);

  logic                     w_load, w_rr_any, w_any, w_hs, w_stick;
  logic [SEL_BITS-1:0]      w_rr_win, w_win, r_last;
  logic [NUM_REQS-1:0]      w_ready;
  int                       w_best, w_dist;

  logic                     r_valid, r_rw;
  logic [BE_WIDTH-1:0]      r_byteen;
  logic [ADDR_WIDTH-1:0]    r_addr;
  logic [DATA_WIDTH-1:0]    r_data;
  logic [TAG_OUT_WIDTH-1:0] r_tag;

  assign w_load = !r_valid || bus.req_out_ready;

  // Smallest rotational distance from last+1 wins.
  always_comb begin
    w_rr_any = 1'b0;
    w_rr_win = '0;
    w_best   = NUM_REQS;
    w_dist   = 0;
    for (int i = 0; i < NUM_REQS; i++) begin
      w_dist = (i + NUM_REQS - 1 - int'(r_last)) % NUM_REQS;
      if (bus.req_in_valid[i] && (w_dist < w_best)) begin
        w_best   = w_dist;
        w_rr_win = SEL_BITS'(i);
        w_rr_any = 1'b1;
      end
    end
  end

`ifdef L1_MEM_ARB_STICKY_EN
  localparam int CNT_W = (MAX_BURST > 2) ? $clog2(MAX_BURST) : 1;

  logic [CNT_W-1:0] r_burst;
  logic             r_elig;

  // r_elig: the previous load granted r_last, so a repeat grant is allowed.
  assign w_stick = r_elig && bus.req_in_valid[r_last] && (r_burst < CNT_W'(MAX_BURST - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_burst <= '0;
      r_elig  <= 1'b0;
    end else if (w_load) begin
      r_elig  <= w_any;
      r_burst <= w_stick ? r_burst + CNT_W'(1) : '0;
    end
  end
`else
  assign w_stick = 1'b0;
`endif

  assign w_any = w_stick || w_rr_any;
  assign w_win = w_stick ? r_last : w_rr_win;
  assign w_hs  = w_load && w_any;

  always_comb begin
    w_ready = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (w_hs && (w_win == SEL_BITS'(i))) w_ready[i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_last  <= LAST_RST;
    end else if (w_load) begin
      r_valid <= w_any;
      if (w_any) r_last <= w_win;
    end
  end

  always_ff @(posedge clk) begin
    if (w_hs) begin
      r_rw     <= bus.req_in_rw[w_win];
      r_byteen <= bus.req_in_byteen[w_win];
      r_addr   <= bus.req_in_addr[w_win];
      r_data   <= bus.req_in_data[w_win];
      r_tag    <= {bus.req_in_tag[w_win], w_win};
    end
  end

  assign bus.req_in_ready   = w_ready;
  assign bus.req_out_valid  = r_valid;
  assign bus.req_out_rw     = r_rw;
  assign bus.req_out_byteen = r_byteen;
  assign bus.req_out_addr   = r_addr;
  assign bus.req_out_data   = r_data;
  assign bus.req_out_tag    = r_tag;

  logic [SEL_BITS-1:0] w_rsp_sel;
  logic [NUM_REQS-1:0] w_rsp_valid;
  logic                w_rsp_ready, w_sel_ok;

  assign w_rsp_sel = bus.rsp_in_tag[SEL_BITS-1:0];

  // Out-of-range selects match no requester and are swallowed.
  always_comb begin
    w_rsp_valid = '0;
    w_rsp_ready = 1'b1;
    w_sel_ok    = 1'b0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (w_rsp_sel == SEL_BITS'(i)) begin
        w_sel_ok       = 1'b1;
        w_rsp_valid[i] = bus.rsp_in_valid;
        w_rsp_ready    = bus.rsp_out_ready[i];
      end
    end
  end

  assign bus.rsp_out_valid = w_rsp_valid;
  assign bus.rsp_in_ready  = w_rsp_ready;
  assign bus.rsp_out_data  = bus.rsp_in_data;
  assign bus.rsp_out_tag   = bus.rsp_in_tag[TAG_OUT_WIDTH-1:SEL_BITS];

  a_cfg:     assert property (@(posedge clk) (NUM_REQS >= 2) && (MAX_BURST >= 1));
  a_rsp_sel: assert property (@(posedge clk) disable iff (reset) bus.rsp_in_valid |-> w_sel_ok);

endmodule
`default_nettype wire

// File: tb/tb_l1_mem_arbiter.sv
`default_nettype none
// ==========================================================================
// tb_l1_mem_arbiter: directed tables, corner sequences and a randomized model.
// Rev 1.0
// ==========================================================================
module tb_l1_mem_arbiter;
  localparam int N   = 5;
  localparam int AW  = 26;
  localparam int DW  = 512;
  localparam int TW  = 8;
  localparam int MB  = 4;
  localparam int SB  = 3;
  localparam int TOW = TW + SB;
`ifdef L1_MEM_ARB_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  l1_mem_arbiter_if #(.NUM_REQS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_IN_WIDTH(TW)) bus ();

  l1_mem_arbiter #(
    .NUM_REQS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_IN_WIDTH(TW), .MAX_BURST(MB)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req_in_valid  = '0;
    bus.req_in_rw     = '0;
    bus.req_in_byteen = '0;
    bus.req_in_addr   = '0;
    bus.req_in_data   = '0;
    bus.req_in_tag    = '0;
    bus.req_out_ready = 1'b1;
    bus.rsp_in_valid  = 1'b0;
    bus.rsp_in_data   = '0;
    bus.rsp_in_tag    = '0;
    bus.rsp_out_ready = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    step();
    step();
    reset = 1'b0;
  endtask

  // Requester i gets tag 0x10+i and address 0x100+i in directed sequences.
  task automatic set_fixed_fields();
    for (int i = 0; i < N; i++) begin
      bus.req_in_tag[i]  = TW'(16 + i);
      bus.req_in_addr[i] = AW'(256 + i);
    end
  endtask

  function automatic logic [63:0] fixed_tag(input int s);
    return 64'(((16 + s) << SB) | s);
  endfunction

  task automatic rand_req_fields();
    for (int i = 0; i < N; i++) begin
      bus.req_in_rw[i]     = 1'($urandom_range(0, 1));
      bus.req_in_addr[i]   = AW'($urandom());
      bus.req_in_tag[i]    = TW'($urandom());
      bus.req_in_byteen[i] = {$urandom(), $urandom()};
      for (int w = 0; w < DW / 32; w++) bus.req_in_data[i][w*32 +: 32] = $urandom();
    end
  endtask

  // Reference model: the pending L2 request and the arbitration history.
  bit             m_valid;
  logic [TOW-1:0] m_tag;
  logic [AW-1:0]  m_addr;
  logic           m_rw;
  logic [63:0]    m_byteen;
  logic [DW-1:0]  m_data;
  int             m_last, m_run;
  bit             m_has;

  task automatic model_reset();
    m_valid = 1'b0;
    m_last  = N - 1;
    m_run   = 0;
    m_has   = 1'b0;
  endtask

  // Winner: continue the current run if allowed, else first valid after the last winner.
  function automatic int pick(input logic [N-1:0] v, output bit stuck);
    stuck = 1'b0;
    if (STICKY && m_has && v[m_last] && (m_run < MB)) begin
      stuck = 1'b1;
      return m_last;
    end
    for (int s = 1; s <= N; s++) begin
      if (v[(m_last + s) % N]) return (m_last + s) % N;
    end
    return -1;
  endfunction

  typedef struct {
    logic           v;
    logic [TOW-1:0] tag;
    logic [N-1:0]   rdy;
    logic [N-1:0]   exp_v;
    logic [TW-1:0]  exp_tag;
    logic           exp_rdy;
  } rsp_vec_t;

  rsp_vec_t rsp_tbl[7];
  int       rr_exp[$];
  int       drop_exp[$];
  int       stall_sel;

  initial begin
    logic [DW-1:0] exp_data;
    logic [N-1:0]  v, exp_ready, ev;
    logic          er, load, rv;
    int            g, rs;
    bit            stuck;

    rsp_tbl[0] = '{1'b1, 11'h2D3, 5'b00000, 5'b01000, 8'h5A, 1'b0};
    rsp_tbl[1] = '{1'b1, 11'h2D3, 5'b01000, 5'b01000, 8'h5A, 1'b1};
    rsp_tbl[2] = '{1'b1, 11'h528, 5'b11110, 5'b00001, 8'hA5, 1'b0};
    rsp_tbl[3] = '{1'b1, 11'h7FC, 5'b10000, 5'b10000, 8'hFF, 1'b1};
    rsp_tbl[4] = '{1'b0, 11'h092, 5'b00100, 5'b00000, 8'h12, 1'b1};
    rsp_tbl[5] = '{1'b0, 11'h007, 5'b00000, 5'b00000, 8'h00, 1'b1};
    rsp_tbl[6] = '{1'b1, 11'h1E1, 5'b11101, 5'b00010, 8'h3C, 1'b0};
    if (STICKY) begin
      rr_exp    = {0, 0, 0, 0, 1, 1, 1, 1, 2};
      drop_exp  = {0, 0, 1};
      stall_sel = 2;
    end else begin
      rr_exp    = {0, 1, 2, 3, 4, 0};
      drop_exp  = {0, 1, 2};
      stall_sel = 1;
    end

    reset = 1'b1;
    clear_inputs();
    do_reset();
    @(negedge clk);
    chk("reset_out_valid", 64'(bus.req_out_valid), 64'd0);
    chk("reset_in_ready", 64'(bus.req_in_ready), 64'd0);

    for (int k = 0; k < 7; k++) begin
      step();
      bus.rsp_in_valid  = rsp_tbl[k].v;
      bus.rsp_in_tag    = rsp_tbl[k].tag;
      bus.rsp_out_ready = rsp_tbl[k].rdy;
      for (int w = 0; w < DW / 32; w++) exp_data[w*32 +: 32] = $urandom();
      bus.rsp_in_data = exp_data;
      @(negedge clk);
      chk("tbl_rsp_valid", 64'(bus.rsp_out_valid), 64'(rsp_tbl[k].exp_v));
      chk("tbl_rsp_tag", 64'(bus.rsp_out_tag), 64'(rsp_tbl[k].exp_tag));
      chk("tbl_rsp_ready", 64'(bus.rsp_in_ready), 64'(rsp_tbl[k].exp_rdy));
      chk("tbl_rsp_data", 64'(bus.rsp_out_data === exp_data), 64'd1);
    end

    // All requesters valid: grant order after reset.
    do_reset();
    set_fixed_fields();
    bus.req_in_valid = '1;
    @(negedge clk);
    chk("rr_first_ready", 64'(bus.req_in_ready), 64'b00001);
    for (int k = 0; k < rr_exp.size(); k++) begin
      step();
      @(negedge clk);
      chk("rr_valid", 64'(bus.req_out_valid), 64'd1);
      chk("rr_tag", 64'(bus.req_out_tag), fixed_tag(rr_exp[k]));
    end

    // Back-pressure for three cycles, then release.
    step();
    bus.req_out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_in_ready", 64'(bus.req_in_ready), 64'd0);
      chk("stall_valid", 64'(bus.req_out_valid), 64'd1);
      chk("stall_tag", 64'(bus.req_out_tag), fixed_tag(stall_sel));
      chk("stall_addr", 64'(bus.req_out_addr), 64'(256 + stall_sel));
      step();
    end
    bus.req_out_ready = 1'b1;
    @(negedge clk);
    chk("release_ready", 64'(bus.req_in_ready), 64'b00100);
    step();
    @(negedge clk);
    chk("release_tag", 64'(bus.req_out_tag), fixed_tag(2));

    // Lone requester 3 with tag 0x5A.
    do_reset();
    bus.req_in_valid  = 5'b01000;
    bus.req_in_tag[3] = 8'h5A;
    @(negedge clk);
    chk("solo_ready", 64'(bus.req_in_ready), 64'b01000);
    step();
    bus.req_in_valid = '0;
    @(negedge clk);
    chk("solo_valid", 64'(bus.req_out_valid), 64'd1);
    chk("solo_tag", 64'(bus.req_out_tag), 64'h2D3);
    chk("solo_idle_ready", 64'(bus.req_in_ready), 64'd0);
    step();
    @(negedge clk);
    chk("idle_clears_valid", 64'(bus.req_out_valid), 64'd0);

    // Requester 0 drops its valid after two grants.
    do_reset();
    set_fixed_fields();
    bus.req_in_valid = '1;
    for (int k = 0; k < 3; k++) begin
      step();
      @(negedge clk);
      chk("drop_tag", 64'(bus.req_out_tag), fixed_tag(drop_exp[k]));
      if (k == 1) bus.req_in_valid = 5'b11110;
    end

    // Reset while a request is pending.
    bus.req_in_valid  = '1;
    bus.req_out_ready = 1'b0;
    step();
    @(negedge clk);
    chk("pre_reset_valid", 64'(bus.req_out_valid), 64'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("mid_reset_valid", 64'(bus.req_out_valid), 64'd0);
    chk("mid_reset_ready", 64'(bus.req_in_ready), 64'b00001);
    bus.req_out_ready = 1'b1;
    step();
    @(negedge clk);
    chk("post_reset_tag", 64'(bus.req_out_tag), fixed_tag(0));

    // Randomized traffic against the reference model.
    do_reset();
    model_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      v = (((cyc / 40) % 2) == 1) ? '1 : N'($urandom_range(0, 31));
      bus.req_in_valid  = v;
      bus.req_out_ready = ($urandom_range(0, 3) != 0);
      rand_req_fields();
      rv = 1'($urandom_range(0, 1));
      rs = rv ? $urandom_range(0, N - 1) : $urandom_range(0, 7);
      bus.rsp_in_valid  = rv;
      bus.rsp_in_tag    = {TW'($urandom()), SB'(rs)};
      bus.rsp_out_ready = N'($urandom_range(0, 31));
      for (int w = 0; w < DW / 32; w++) bus.rsp_in_data[w*32 +: 32] = $urandom();
      @(negedge clk);

      load      = !m_valid || bus.req_out_ready;
      g         = pick(v, stuck);
      exp_ready = (load && (g >= 0)) ? N'(1 << g) : '0;
      chk("rand_in_ready", 64'(bus.req_in_ready), 64'(exp_ready));
      chk("rand_out_valid", 64'(bus.req_out_valid), 64'(m_valid));
      if (m_valid) begin
        chk("rand_out_tag", 64'(bus.req_out_tag), 64'(m_tag));
        chk("rand_out_addr", 64'(bus.req_out_addr), 64'(m_addr));
        chk("rand_out_rw", 64'(bus.req_out_rw), 64'(m_rw));
        chk("rand_out_byteen", 64'(bus.req_out_byteen), m_byteen);
        chk("rand_out_data", 64'(bus.req_out_data === m_data), 64'd1);
      end

      ev = (rv && (rs < N)) ? N'(1 << rs) : '0;
      er = (rs < N) ? bus.rsp_out_ready[rs] : 1'b1;
      chk("rand_rsp_valid", 64'(bus.rsp_out_valid), 64'(ev));
      chk("rand_rsp_ready", 64'(bus.rsp_in_ready), 64'(er));
      chk("rand_rsp_tag", 64'(bus.rsp_out_tag), 64'(bus.rsp_in_tag >> SB));
      chk("rand_rsp_data", 64'(bus.rsp_out_data === bus.rsp_in_data), 64'd1);

      if (load) begin
        if (g >= 0) begin
          m_valid  = 1'b1;
          m_tag    = {bus.req_in_tag[g], SB'(g)};
          m_addr   = bus.req_in_addr[g];
          m_rw     = bus.req_in_rw[g];
          m_byteen = bus.req_in_byteen[g];
          m_data   = bus.req_in_data[g];
          m_run    = stuck ? m_run + 1 : 1;
          m_last   = g;
          m_has    = 1'b1;
        end else begin
          m_valid = 1'b0;
          m_has   = 1'b0;
          m_run   = 0;
        end
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "time limit");
  end

endmodule
`default_nettype wire
